// File: rtl/key_load_seq_if.sv
// Serial key-stream handshake between the key-provisioning side (master)
// and the key-load sequencer (slave).
interface key_load_seq_if;
   logic key_valid;
   logic key_bit;
   logic key_last;
   logic key_ready;

   modport master (
      output key_valid,
      output key_bit,
      output key_last,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_bit,
      input  key_last,
      output key_ready
   );
endinterface

// File: rtl/key_load_seq.sv
// Key-load sequencer: collects a serial key plus one parity beat, checks the
// length and the even parity, then presents the key in parallel and releases
// the locked FSM from reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | locked FSM held in reset, waiting for start
// S_LOAD  | accepting key beats (MSB first), then the parity beat
// S_CHECK | one cycle: parity check over the collected key
// S_RUN   | key presented on key_out, locked FSM released
// S_ERR   | bad length or parity; locked FSM held in reset until clear
module key_load_seq #(
   parameter int KEY_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clear,
   key_load_seq_if.slave      kbus,
   output logic [KEY_W-1:0]   key_out,
   output logic               fsm_rst,
   output logic               done,
   output logic               err
);

   localparam int CW = $clog2(KEY_W + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [KEY_W-1:0]  sr;
   logic              par;
   logic              beat;
   logic              par_beat;

   logic              key_ready_nx;
   logic              fsm_rst_nx;
   logic              done_nx;
   logic              err_nx;
   logic [KEY_W-1:0]  key_out_nx;

   // key_ready is registered and high only in LOAD, so this is the accept strobe
   assign beat     = (state == S_LOAD) && kbus.key_ready && kbus.key_valid;
   assign par_beat = (cnt == CW'(KEY_W));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; clear overrides every other input
   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD: begin
               if (beat) begin
                  if (par_beat)           state_nx = kbus.key_last ? S_CHECK : S_ERR;
                  else if (kbus.key_last) state_nx = S_ERR;
               end
            end
            S_CHECK: state_nx = (^sr ^ par) ? S_ERR : S_RUN;
            S_RUN:   state_nx = S_RUN;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Output decode from the next state so every output is a plain register
   always_comb begin
      key_ready_nx = (state_nx == S_LOAD);
      fsm_rst_nx   = (state_nx != S_RUN);
      done_nx      = (state_nx == S_RUN);
      err_nx       = (state_nx == S_ERR);
      key_out_nx   = '0;
      // the key is captured only on the CHECK->RUN step and frozen while running
      if (state_nx == S_RUN) key_out_nx = (state == S_CHECK) ? sr : key_out;
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kbus.key_ready <= 1'b0;
         fsm_rst        <= 1'b1;
         done           <= 1'b0;
         err            <= 1'b0;
         key_out        <= '0;
      end else begin
         kbus.key_ready <= key_ready_nx;
         fsm_rst        <= fsm_rst_nx;
         done           <= done_nx;
         err            <= err_nx;
         key_out        <= key_out_nx;
      end
   end

   // Beat counter, key shift register and parity capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sr  <= '0;
         par <= 1'b0;
      end else if (clear) begin
         cnt <= '0;
      end else if ((state == S_IDLE) && start) begin
         cnt <= '0;
         sr  <= '0;
      end else if (beat) begin
         if (par_beat) begin
            par <= kbus.key_bit;
         end else begin
            sr  <= {sr[KEY_W-2:0], kbus.key_bit};
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_key_load_seq.sv
// Bench for key_load_seq: a queue-based model of the key-load rules checked on
// every cycle, directed scenarios with literal expectations, and a random phase.
module tb_key_load_seq;
   localparam int KEY_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             clear;
   logic [KEY_W-1:0] key_out;
   logic             fsm_rst;
   logic             done;
   logic             err;

   key_load_seq_if kif();

   key_load_seq #(.KEY_W(KEY_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .clear   (clear),
      .kbus    (kif.slave),
      .key_out (key_out),
      .fsm_rst (fsm_rst),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc_n   = 0;

   always @(posedge clk) cyc_n++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model phases: 0 idle, 1 loading, 2 checking, 3 running, 4 error
   int               m_ph  = 0;
   bit               m_q[$];
   logic [KEY_W-1:0] m_key = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0;
         m_q.delete();
         m_key = '0;
      end else if (clear) begin
         m_ph = 0;
         m_q.delete();
      end else begin
         case (m_ph)
            0: if (start) begin
               m_ph = 1;
               m_q.delete();
            end
            1: if (kif.key_valid) begin
               m_q.push_back(kif.key_bit);
               if (kif.key_last != (m_q.size() == KEY_W + 1)) m_ph = 4;
               else if (m_q.size() == KEY_W + 1)              m_ph = 2;
            end
            2: begin
               int ones;
               ones = 0;
               for (int i = 0; i <= KEY_W; i++) ones += int'(m_q[i]);
               for (int i = 0; i < KEY_W; i++) m_key[KEY_W-1-i] = m_q[i];
               m_ph = (ones % 2 == 0) ? 3 : 4;
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("key_ready", kif.key_ready, m_ph == 1);
      chk("fsm_rst",   fsm_rst,       m_ph != 3);
      chk("done",      done,          m_ph == 3);
      chk("err",       err,           m_ph == 4);
      chk("key_out",   key_out,       (m_ph == 3) ? m_key : '0);
   end

   task automatic drive(input logic s, input logic c, input logic v, input logic b, input logic l);
      @(negedge clk);
      start         = s;
      clear         = c;
      kif.key_valid = v;
      kif.key_bit   = b;
      kif.key_last  = l;
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) drive(0, 0, 0, 0, 0);
   endtask

   task automatic load_key(input logic [KEY_W-1:0] k, input logic p, input bit bubbles,
                           output int last_edge);
      logic [KEY_W:0] stream;
      stream    = {k, p};
      last_edge = -1;
      for (int i = 0; i <= KEY_W; i++) begin
         drive(0, 0, 1, stream[KEY_W-i], i == KEY_W);
         last_edge = cyc_n + 1;
         if (bubbles) drive(0, 0, 0, 1'($urandom % 2), 1'($urandom % 2));
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic wait_done(output int at);
      at = -1;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) begin
            at = cyc_n;
            break;
         end
         drive(0, 0, 0, 0, 0);
      end
      if (at < 0) chk("done_timeout", 0, 1);
   endtask

   int s_edge;
   int l_edge;
   int at;

   initial begin
      rst = 1'b1;
      start = 0; clear = 0;
      kif.key_valid = 0; kif.key_bit = 0; kif.key_last = 0;
      repeat (3) @(negedge clk);
      chk("rst_fsm_rst",   fsm_rst,       1);
      chk("rst_key_ready", kif.key_ready, 0);
      chk("rst_done",      done,          0);
      chk("rst_err",       err,           0);
      chk("rst_key_out",   key_out,       0);
      rst = 1'b0;
      idle_cyc(2);

      // nominal load of 8'hA5, even parity
      drive(1, 0, 0, 0, 0);
      s_edge = cyc_n + 1;
      load_key(8'hA5, 1'b0, 0, l_edge);
      wait_done(at);
      chk("nominal_latency", at - s_edge, 10);
      chk("nominal_key",     key_out,     8'hA5);
      chk("nominal_fsm_rst", fsm_rst,     0);
      drive(0, 1, 0, 0, 0);
      idle_cyc(1);

      // parity failure, then clear
      drive(1, 0, 0, 0, 0);
      load_key(8'hA5, 1'b1, 0, l_edge);
      idle_cyc(1);
      chk("parfail_err",     err,     1);
      chk("parfail_fsm_rst", fsm_rst, 1);
      chk("parfail_key_out", key_out, 0);
      chk("parfail_done",    done,    0);
      drive(0, 1, 0, 0, 0);
      idle_cyc(1);
      chk("parfail_clear_err", err, 0);

      // early key_last on beat 3
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0);
      drive(0, 0, 1, 0, 1);
      drive(0, 0, 1, 1, 0);
      chk("early_err",   err,           1);
      chk("early_ready", kif.key_ready, 0);
      repeat (3) drive(0, 0, 1, 1, 0);
      chk("early_held_err", err, 1);
      drive(0, 1, 0, 0, 0);
      idle_cyc(1);

      // bubbles while loading 8'h3C
      drive(1, 0, 0, 0, 0);
      s_edge = cyc_n + 1;
      load_key(8'h3C, 1'b0, 1, l_edge);
      wait_done(at);
      chk("bubble_key",       key_out,      8'h3C);
      chk("bubble_run_delay", at - l_edge,  1);
      chk("bubble_latency",   at - s_edge,  18);
      drive(0, 1, 0, 0, 0);
      idle_cyc(1);

      // abort after 4 beats, clear together with start, then a fresh 8'hFF load
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, i[0], 0);
      drive(1, 1, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      chk("clear_beats_start", kif.key_ready, 0);
      drive(1, 0, 0, 0, 0);
      load_key(8'hFF, 1'b0, 0, l_edge);
      wait_done(at);
      chk("abort_key",  key_out, 8'hFF);
      chk("abort_done", done,    1);
      idle_cyc(2);
      chk("run_key_stable", key_out, 8'hFF);

      // async reset between edges while running
      #2 rst = 1'b1;
      #1;
      chk("arst_fsm_rst", fsm_rst, 1);
      chk("arst_key_out", key_out, 0);
      chk("arst_done",    done,    0);
      drive(1, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 0);
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk("arst_start_ignored", kif.key_ready, 0);
      idle_cyc(1);

      // random phase
      for (int n = 0; n < 600; n++) begin
         drive(($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
               1'($urandom % 2),
               (m_q.size() == KEY_W) ^ (($urandom % 10) == 0));
      end
      drive(0, 1, 0, 0, 0);
      idle_cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
